// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: width defaults, instruction
// class nibbles, FSM state encoding and the instruction-class decoder.
package seq_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ADDR_WIDTH = 8;

    localparam logic [3:0] CLS_NOP  = 4'h0;
    localparam logic [3:0] CLS_ALU  = 4'h1;
    localparam logic [3:0] CLS_LDI  = 4'h2;
    localparam logic [3:0] CLS_JMP  = 4'h3;
    localparam logic [3:0] CLS_BRF  = 4'h4;
    localparam logic [3:0] CLS_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_HALT  = 3'd4
    } seq_state_e;

    typedef struct packed {
        logic exec;    // ALU or LDI: present the words to the datapath
        logic jump;
        logic branch;
        logic halt;
    } instr_decode_t;

    // Unlisted class nibbles fall out as all-zero, i.e. a NOP.
    function automatic instr_decode_t decode_class(input logic [3:0] cls);
        instr_decode_t dec;
        dec = '0;
        case (cls)
            CLS_ALU, CLS_LDI: dec.exec   = 1'b1;
            CLS_JMP:          dec.jump   = 1'b1;
            CLS_BRF:          dec.branch = 1'b1;
            CLS_HALT:         dec.halt   = 1'b1;
            default:          dec        = '0;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/seq_pc.sv
// Program counter for the instruction sequencer: synchronous load has priority
// over increment; increment wraps modulo 2^ADDR_WIDTH.
module seq_pc
    import seq_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic                  inc_en,
    output logic [ADDR_WIDTH-1:0] pc
);

    logic [ADDR_WIDTH-1:0] pc_d;
    logic [ADDR_WIDTH-1:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = load_addr;
        end else if (inc_en) begin
            pc_d = pc_q + ADDR_WIDTH'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would make results depend on process order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch / wait / issue sequencer driving an ALU datapath from instruction memory.
// Define SEQ_BRANCH_EN to enable JMP and BRF; otherwise both decode as NOP.
module instruction_sequencer
    import seq_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic                  imem_req,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_opcode,
    input  logic [DATA_WIDTH-1:0] imem_operand,
    output logic [DATA_WIDTH-1:0] opcode,
    output logic [DATA_WIDTH-1:0] operand,
    input  logic [3:0]            alu_flags,
    output logic                  busy,
    output logic                  halted,
    output logic [ADDR_WIDTH-1:0] pc
);

    seq_state_e state_d;
    seq_state_e state_q;

    logic                  ack_d;
    logic                  ack_q;
    logic [DATA_WIDTH-1:0] instr_opcode_d;
    logic [DATA_WIDTH-1:0] instr_opcode_q;
    logic [DATA_WIDTH-1:0] instr_operand_d;
    logic [DATA_WIDTH-1:0] instr_operand_q;

    instr_decode_t         dec;
    logic                  taken;
    logic                  capture;
    logic                  start_accept;
    logic                  pc_load;
    logic                  pc_inc;
    logic [ADDR_WIDTH-1:0] pc_load_addr;

    assign dec          = decode_class(instr_opcode_q[15:12]);
    assign start_accept = start && ((state_q == S_IDLE) || (state_q == S_HALT));
    assign capture      = (state_q == S_WAIT) && imem_ack && !ack_q;

`ifdef SEQ_BRANCH_EN
    assign taken = dec.jump || (dec.branch && ((alu_flags & instr_opcode_q[3:0]) != 4'b0000));
`else
    logic branch_unused;
    assign branch_unused = ^{alu_flags, dec.jump, dec.branch};
    assign taken         = 1'b0;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // The acknowledge is registered before leaving WAIT, so one instruction
    // costs FETCH + ack latency + ack register + ISSUE cycles.
    always_comb begin
        // NOTE: every combinational output gets a default before the case so no
        // path leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: state_d = S_WAIT;
            S_WAIT:  if (ack_q) state_d = S_ISSUE;
            S_ISSUE: state_d = dec.halt ? S_HALT : S_FETCH;
            S_HALT:  if (start) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        imem_req = 1'b0;
        busy     = 1'b0;
        halted   = 1'b0;
        opcode   = '0;
        operand  = '0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                busy     = 1'b1;
            end
            S_WAIT:  busy = 1'b1;
            S_ISSUE: begin
                busy = 1'b1;
                if (dec.exec) begin
                    opcode  = instr_opcode_q;
                    operand = instr_operand_q;
                end
            end
            S_HALT:  halted = 1'b1;
            default: begin
                imem_req = 1'b0;
                busy     = 1'b0;
            end
        endcase
    end

    // ---------------- instruction registers ----------------
    // Only the first ack seen in WAIT is captured; acks in any other state,
    // including one still in flight across a reset, are dropped.
    always_comb begin
        ack_d           = capture;
        instr_opcode_d  = instr_opcode_q;
        instr_operand_d = instr_operand_q;
        if (capture) begin
            instr_opcode_d  = imem_opcode;
            instr_operand_d = imem_operand;
        end
    end

    // NOTE: the instruction registers are reset along with the control state so
    // a reset mid-fetch cannot leave a stale instruction to be issued later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_q           <= 1'b0;
            instr_opcode_q  <= '0;
            instr_operand_q <= '0;
        end else begin
            ack_q           <= ack_d;
            instr_opcode_q  <= instr_opcode_d;
            instr_operand_q <= instr_operand_d;
        end
    end

    // ---------------- program counter control ----------------
    // A HALT issues neither a load nor an increment, so pc keeps the HALT address.
    always_comb begin
        pc_load      = 1'b0;
        pc_inc       = 1'b0;
        pc_load_addr = start_addr;
        if (start_accept) begin
            pc_load = 1'b1;
        end else if (state_q == S_ISSUE) begin
            pc_load_addr = instr_operand_q[ADDR_WIDTH-1:0];
            pc_load      = taken;
            pc_inc       = !taken && !dec.halt;
        end
    end

    seq_pc #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pc (
        .clk       (clk),
        .reset     (reset),
        .load_en   (pc_load),
        .load_addr (pc_load_addr),
        .inc_en    (pc_inc),
        .pc        (pc)
    );

    assign imem_addr = pc;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: a table of single-instruction
// programs plus hand-written sequences for start-while-busy and reset-in-WAIT.
module tb_instruction_sequencer;

`ifdef SEQ_BRANCH_EN
    localparam bit BR = 1'b1;
`else
    localparam bit BR = 1'b0;
`endif
    localparam int BUDGET = 60;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  start_addr;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [15:0] imem_opcode;
    logic [15:0] imem_operand;
    logic [15:0] opcode;
    logic [15:0] operand;
    logic [3:0]  alu_flags;
    logic        busy;
    logic        halted;
    logic [7:0]  pc;

    instruction_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .start_addr   (start_addr),
        .imem_addr    (imem_addr),
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .imem_opcode  (imem_opcode),
        .imem_operand (imem_operand),
        .opcode       (opcode),
        .operand      (operand),
        .alu_flags    (alu_flags),
        .busy         (busy),
        .halted       (halted),
        .pc           (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else passed++;
    endtask

    // ---------------- instruction memory model ----------------
    logic [15:0] mem_opc [256];
    logic [15:0] mem_opr [256];
    int          lat_cfg = 1;

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) begin
            mem_opc[i] = 16'hF000;
            mem_opr[i] = 16'h0000;
        end
    endtask

    // Ack is driven lat_cfg cycles after the cycle in which imem_req is seen;
    // data words carry junk whenever ack is low.
    initial begin
        int         cnt;
        logic [7:0] req_addr;
        cnt          = 0;
        req_addr     = '0;
        imem_ack     = 1'b0;
        imem_opcode  = 16'hDEAD;
        imem_operand = 16'hBEEF;
        forever begin
            @(negedge clk);
            imem_ack     = 1'b0;
            imem_opcode  = 16'hDEAD;
            imem_operand = 16'hBEEF;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    imem_ack     = 1'b1;
                    imem_opcode  = mem_opc[req_addr];
                    imem_operand = mem_opr[req_addr];
                end
            end
            if (imem_req === 1'b1) begin
                req_addr = imem_addr;
                cnt      = lat_cfg;
            end
        end
    end

    // ---------------- program runner ----------------
    int          k_done;
    bit          done;
    int          nfetch;
    logic [7:0]  fetch_addr [4];
    int          fetch_k    [4];
    int          nexec;
    int          exec_k;
    logic [15:0] seen_opc;
    logic [15:0] seen_opr;
    logic        busy_at1;
    logic        halted_at1;

    // k counts rising edges after the one that samples start; glitch_k (>=2)
    // pulses start again mid-run, 0 disables it.
    task automatic run(input logic [7:0] addr, input int glitch_k, input logic [7:0] glitch_addr);
        int k;
        nfetch = 0; nexec = 0; exec_k = 0; done = 0;
        seen_opc = '0; seen_opr = '0;
        @(negedge clk);
        start = 1'b1;
        start_addr = addr;
        k = 0;
        while (!done && k < BUDGET) begin
            @(negedge clk);
            k++;
            start = (k == glitch_k);
            if (k == glitch_k) start_addr = glitch_addr;
            if (k == 1) begin
                busy_at1   = busy;
                halted_at1 = halted;
            end
            if (imem_req === 1'b1) begin
                if (nfetch < 4) begin
                    fetch_addr[nfetch] = imem_addr;
                    fetch_k[nfetch]    = k;
                end
                nfetch++;
            end
            if (opcode !== 16'h0 || operand !== 16'h0) begin
                if (nexec == 0) begin
                    exec_k   = k;
                    seen_opc = opcode;
                    seen_opr = operand;
                end
                nexec++;
            end
            if (halted === 1'b1) done = 1'b1;
        end
        start = 1'b0;
        k_done = k;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic [7:0]  addr;
        logic [15:0] opc;
        logic [15:0] opr;
        logic [3:0]  flags;
        int          lat;
        int          exp_nexec;
        logic [15:0] exp_opc;
        logic [15:0] exp_opr;
        int          exp_nfetch;
        logic [7:0]  exp_fetch2;
        logic [7:0]  exp_halt_pc;
    } vec_t;

    vec_t vecs [10];

    task automatic run_vec(input vec_t v);
        fill_halt();
        mem_opc[v.addr] = v.opc;
        mem_opr[v.addr] = v.opr;
        alu_flags = v.flags;
        lat_cfg   = v.lat;
        run(v.addr, 0, 8'h00);
        check({v.name, ".done"}, {31'd0, done}, 32'd1);
        check({v.name, ".start_busy"}, {30'd0, busy_at1, halted_at1}, 32'b10);
        check({v.name, ".fetch0"}, {24'd0, fetch_addr[0]}, {24'd0, v.addr});
        check({v.name, ".nfetch"}, nfetch, v.exp_nfetch);
        check({v.name, ".nexec"}, nexec, v.exp_nexec);
        if (v.exp_nexec > 0) begin
            check({v.name, ".opcode"}, {16'd0, seen_opc}, {16'd0, v.exp_opc});
            check({v.name, ".operand"}, {16'd0, seen_opr}, {16'd0, v.exp_opr});
            check({v.name, ".exec_cycle"}, exec_k, v.lat + 3);
        end
        if (v.exp_nfetch > 1) begin
            check({v.name, ".fetch2"}, {24'd0, fetch_addr[1]}, {24'd0, v.exp_fetch2});
            check({v.name, ".period"}, fetch_k[1] - fetch_k[0], v.lat + 3);
        end
        check({v.name, ".halt_pc"}, {24'd0, pc}, {24'd0, v.exp_halt_pc});
        check({v.name, ".halt_flags"}, {30'd0, busy, halted}, 32'b01);
    endtask

    initial begin
        logic bad;
        reset = 1'b0; start = 1'b0; start_addr = '0; alu_flags = '0;
        fill_halt();

        vecs[0] = '{"ldi_prog",  8'h00, 16'h2003, 16'h0005, 4'h0, 1, 1, 16'h2003, 16'h0005, 2, 8'h01, 8'h01};
        vecs[1] = '{"alu_lat4",  8'h00, 16'h1002, 16'h0100, 4'h0, 4, 1, 16'h1002, 16'h0100, 2, 8'h01, 8'h01};
        vecs[2] = '{"nop_wrap",  8'hFF, 16'h0000, 16'h1234, 4'h0, 2, 0, 16'h0000, 16'h0000, 2, 8'h00, 8'h00};
        vecs[3] = '{"jmp",       8'h00, 16'h3000, 16'h0010, 4'h0, 1, 0, 16'h0000, 16'h0000, 2,
                    BR ? 8'h10 : 8'h01, BR ? 8'h10 : 8'h01};
        vecs[4] = '{"brf_taken", 8'h00, 16'h4001, 16'h0020, 4'b0001, 1, 0, 16'h0000, 16'h0000, 2,
                    BR ? 8'h20 : 8'h01, BR ? 8'h20 : 8'h01};
        vecs[5] = '{"brf_not",   8'h00, 16'h4001, 16'h0020, 4'b0010, 1, 0, 16'h0000, 16'h0000, 2, 8'h01, 8'h01};
        vecs[6] = '{"undef_nop", 8'h30, 16'h7ABC, 16'h5555, 4'h0, 3, 0, 16'h0000, 16'h0000, 2, 8'h31, 8'h31};
        vecs[7] = '{"halt_only", 8'h10, 16'hF000, 16'h0000, 4'h0, 2, 0, 16'h0000, 16'h0000, 1, 8'h00, 8'h10};
        vecs[8] = '{"ldi_hi",    8'h40, 16'h2ABC, 16'hBEEF, 4'h0, 2, 1, 16'h2ABC, 16'hBEEF, 2, 8'h41, 8'h41};
        vecs[9] = '{"jmp_trunc", 8'hFF, 16'h3000, 16'h0105, 4'h0, 1, 0, 16'h0000, 16'h0000, 2,
                    BR ? 8'h05 : 8'h00, BR ? 8'h05 : 8'h00};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset.outputs", {pc, imem_addr, 3'd0, imem_req, busy, halted, 2'd0, opcode}, 32'h0);
        check("reset.operand", {16'd0, operand}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("idle.outputs", {pc, 5'd0, imem_req, busy, halted, opcode}, 32'h0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // start pulses while busy must not disturb the running program
        fill_halt();
        mem_opc[8'h00] = 16'h2003; mem_opr[8'h00] = 16'h0005;
        mem_opc[8'h80] = 16'h2777; mem_opr[8'h80] = 16'h0007;
        alu_flags = 4'h0;
        lat_cfg   = 3;
        run(8'h00, 3, 8'h80);
        check("busy_start_wait.fetch2", {24'd0, fetch_addr[1]}, 32'h01);
        check("busy_start_wait.opcode", {16'd0, seen_opc}, 32'h2003);
        check("busy_start_wait.halt_pc", {24'd0, pc}, 32'h01);
        run(8'h00, 6, 8'h80);
        check("busy_start_issue.fetch2", {24'd0, fetch_addr[1]}, 32'h01);
        check("busy_start_issue.halt_pc", {24'd0, pc}, 32'h01);
        check("busy_start_issue.nfetch", nfetch, 2);

        // reset asserted mid-cycle in WAIT; the in-flight ack lands afterwards
        fill_halt();
        mem_opc[8'h05] = 16'h2111; mem_opr[8'h05] = 16'h2222;
        lat_cfg = 5;
        @(negedge clk);
        start = 1'b1; start_addr = 8'h05;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("rst_wait.pre_pc", {24'd0, pc}, 32'h05);
        check("rst_wait.pre_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_wait.async", {pc, imem_addr, 5'd0, imem_req, busy, halted}, 32'h0);
        check("rst_wait.async_data", {opcode, operand}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pc !== 8'h0 || imem_req !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 ||
                opcode !== 16'h0 || operand !== 16'h0) bad = 1'b1;
        end
        check("rst_wait.ack_ignored", {31'd0, bad}, 32'd0);

        run_vec('{"post_reset", 8'h00, 16'h1234, 16'h00AA, 4'h0, 2, 1, 16'h1234, 16'h00AA, 2, 8'h01, 8'h01});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
